// File: rtl/uart_rx18.sv
// uart_rx18: receiver for the 20-bit frame of the 18-channel transmitter.
// Frame is start (0), DATA_BITS data bits LSB first, stop (1). Each bit is
// sampled once at its centre from the synchronised line. Good frames are
// presented on rx_data with a one-cycle rx_valid. A low stop bit raises a
// one-cycle rx_frame_err, bumps a saturating error counter and parks the
// receiver until the line returns high.
module uart_rx18 #(
  parameter int unsigned CLKS_PER_BIT = 576,
  parameter int unsigned DATA_BITS    = 18,
  parameter int unsigned ERR_W        = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_reset,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy,
  output logic [ERR_W-1:0]     rx_err_cnt
);

  localparam int unsigned Half = CLKS_PER_BIT / 2;
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);

  localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e               state_q, state_d;
  logic                 rxd_meta_q, rxd_s_q;
  logic [CntW-1:0]      clk_cnt_q, clk_cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // State, counters, shift register and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next-state logic: bit timing, sampling and frame acceptance.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      StIdle: begin
        clk_cnt_d = '0;
        if (!rxd_s_q) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (clk_cnt_q == HalfLast) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          // Line back high by mid start bit: treat as noise.
          state_d   = rxd_s_q ? StIdle : StData;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StData: begin
        if (clk_cnt_q == BitLast) begin
          clk_cnt_d = '0;
          for (int unsigned i = 0; i < DATA_BITS; i++) begin
            if (bit_cnt_q == BitW'(i)) begin
              shift_d[i] = rxd_s_q;
            end
          end
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == DataLast) begin
            state_d = StStop;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StStop: begin
        if (clk_cnt_q == BitLast) begin
          clk_cnt_d = '0;
          if (rxd_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            state_d = StBreak;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StBreak: begin
        // A held-low line must go high before a new start is recognised.
        clk_cnt_d = '0;
        if (rxd_s_q) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = (state_q != StIdle);
  assign rx_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_rx18.sv
// tb_uart_rx18: randomized frames against a queue-based model of expected
// receive events (good word or framing error with the expected counter).
module tb_uart_rx18;

  localparam int unsigned Cpb = 8;
  localparam int unsigned Nb  = 18;

  logic          sys_clk;
  logic          sys_reset;
  logic          uart_rxd;
  logic [Nb-1:0] rx_data;
  logic          rx_valid;
  logic          rx_frame_err;
  logic          rx_busy;
  logic [7:0]    rx_err_cnt;

  uart_rx18 #(
    .CLKS_PER_BIT(Cpb),
    .DATA_BITS   (Nb),
    .ERR_W       (8)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_reset   (sys_reset),
    .uart_rxd    (uart_rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy),
    .rx_err_cnt  (rx_err_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference model: one entry per frame that must produce a pulse.
  typedef struct {
    bit            err;
    logic [Nb-1:0] data;  // new word (good) or held word (error)
    logic [7:0]    cnt;
  } exp_t;

  exp_t          exp_q[$];
  logic [Nb-1:0] last_good = '0;
  logic [7:0]    model_err = '0;

  function automatic void expect_frame(input logic [Nb-1:0] d, input logic stop);
    exp_t e;
    if (stop) begin
      last_good = d;
    end else if (model_err != 8'hFF) begin
      model_err = model_err + 8'd1;
    end
    e.err  = !stop;
    e.data = last_good;
    e.cnt  = model_err;
    exp_q.push_back(e);
  endfunction

  // Monitor: every pulse must match the head of the expectation queue.
  logic prev_pulse = 1'b0;
  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_reset && (rx_valid || rx_frame_err)) begin
      check("pulse_width", {31'd0, prev_pulse}, 32'd0);
      check("both_pulses", {31'd0, rx_valid & rx_frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        check("spurious_pulse", {30'd0, rx_valid, rx_frame_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {31'd0, rx_frame_err}, {31'd0, e.err});
        check("rx_data", rx_data, e.data);
        check("rx_err_cnt", rx_err_cnt, e.cnt);
      end
    end
    prev_pulse <= rx_valid | rx_frame_err;
  end

  task automatic drive_bits(input logic v, input int unsigned n);
    uart_rxd = v;
    repeat (n) @(negedge sys_clk);
  endtask

  // Sends one frame; a low stop bit is stretched by low_extra cycles.
  task automatic send_frame(input logic [Nb-1:0] d, input logic stop,
                            input int unsigned low_extra, input int unsigned idle_after);
    expect_frame(d, stop);
    drive_bits(1'b0, Cpb);
    for (int i = 0; i < Nb; i++) drive_bits(d[i], Cpb);
    drive_bits(stop, Cpb);
    if (!stop) drive_bits(1'b0, low_extra);
    drive_bits(1'b1, idle_after);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4 * Cpb && exp_q.size() != 0; i++) @(negedge sys_clk);
    check(tag, exp_q.size(), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"}, rx_data, 32'd0);
    check({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
    check({tag, "_ferr"}, {31'd0, rx_frame_err}, 32'd0);
    check({tag, "_busy"}, {31'd0, rx_busy}, 32'd0);
    check({tag, "_cnt"}, rx_err_cnt, 32'd0);
  endtask

  initial begin
    logic [Nb-1:0] d;
    logic          stop;
    uart_rxd  = 1'b1;
    sys_reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_idle_outputs("reset");
    sys_reset = 1'b0;
    repeat (4) @(negedge sys_clk);

    // T1: single good frame.
    send_frame(18'h2A5C3, 1'b1, 0, Cpb);
    check("t1_data", rx_data, 32'h2A5C3);
    check("t1_cnt", rx_err_cnt, 32'd0);

    // T2: short low glitch is rejected at mid start bit.
    uart_rxd = 1'b0;
    repeat (2) @(negedge sys_clk);
    uart_rxd = 1'b1;
    @(negedge sys_clk);
    check("t2_busy_high", {31'd0, rx_busy}, 32'd1);
    repeat (6) @(negedge sys_clk);
    check("t2_busy_low", {31'd0, rx_busy}, 32'd0);
    check("t2_data", rx_data, 32'h2A5C3);
    check("t2_queue", exp_q.size(), 32'd0);

    // T3: bad stop held low two bits, then a good frame.
    send_frame(18'h3FFFF, 1'b0, 2 * Cpb, Cpb);
    check("t3_cnt", rx_err_cnt, 32'd1);
    check("t3_hold", rx_data, 32'h2A5C3);
    send_frame(18'h00001, 1'b1, 0, Cpb);
    check("t3_next", rx_data, 32'h00001);

    // T4: back-to-back frames with a single stop bit each.
    send_frame(18'h00000, 1'b1, 0, 0);
    send_frame(18'h3FFFF, 1'b1, 0, 0);
    send_frame(18'h15555, 1'b1, 0, Cpb);
    drain("t4_drain");

    // Random frames, random gaps, occasional bad stop bits.
    for (int k = 0; k < 30; k++) begin
      d    = Nb'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      if (stop) send_frame(d, 1'b1, 0, $urandom_range(0, 2 * Cpb));
      else      send_frame(d, 1'b0, $urandom_range(0, 2 * Cpb), $urandom_range(Cpb, 2 * Cpb));
    end
    drain("rand_drain");

    // T5: reset during data bit 9; upper bits are ones so the tail looks idle.
    d = {9'h1FF, 9'h0A5};
    drive_bits(1'b0, Cpb);
    for (int i = 0; i < 9; i++) drive_bits(d[i], Cpb);
    drive_bits(1'b1, Cpb / 2);
    sys_reset = 1'b1;
    @(negedge sys_clk);
    sys_reset = 1'b0;
    check_idle_outputs("t5");
    last_good = '0;
    model_err = '0;
    drive_bits(1'b1, Cpb / 2 + 9 * Cpb + 2 * Cpb);
    check("t5_quiet", {31'd0, rx_busy}, 32'd0);
    d = Nb'($urandom);
    send_frame(d, 1'b1, 0, Cpb);
    check("t5_next", rx_data, {14'd0, d});

    // T6: counter saturation over 257 bad frames.
    for (int k = 1; k <= 257; k++) begin
      send_frame(Nb'($urandom), 1'b0, 0, Cpb);
      if (k == 254) check("t6_254", rx_err_cnt, 32'hFE);
      if (k == 256) check("t6_256", rx_err_cnt, 32'hFF);
    end
    check("t6_257", rx_err_cnt, 32'hFF);
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
